// File: rtl/input_port.sv
// input_port: synchronised, debounced switch input with valid/read handshake for the cpu IN path
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst   - asynchronous reset, active-low
//   i_sw    - raw asynchronous switch inputs
//   i_rd    - cpu read strobe, one cycle per IN instruction
//   o_data  - last committed (debounced) switch value
//   o_valid - committed value changed since last read
//   o_ovr   - overrun: commit while o_valid already set (only with INPUT_PORT_OVERRUN_EN)
// Optional feature macro: INPUT_PORT_OVERRUN_EN (undefined: o_ovr tied low)
module input_port #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_ovr
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             w_commit;
  // commit only after a full stable window, and only when the value actually differs
  assign w_commit = (r_sync2 == r_cand) && (r_cnt == LAST) && (r_cand != r_data);
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      // one counter shared by the whole word: any bit change restarts the window
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit) r_data <= r_cand;
      // a commit on the same edge as a read keeps valid set: the new data is unread
      r_valid <= w_commit | (r_valid & ~i_rd);
    end
  end
`ifdef INPUT_PORT_OVERRUN_EN
  logic r_ovr;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_ovr <= 1'b0;
    else        r_ovr <= (w_commit & r_valid & ~i_rd) | (r_ovr & ~i_rd);
  end
  assign o_ovr = r_ovr;
`else
  assign o_ovr = 1'b0;
`endif
  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: tb/tb_input_port.sv
// tb_input_port: directed scoreboard bench for input_port with a 4-cycle debounce window
module tb_input_port;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid, ovr;
  int n_assert = 0;
  int n_fail = 0;
  typedef struct packed {logic [7:0] d; logic v; logic o;} exp_t;
  exp_t q[$];
`ifdef INPUT_PORT_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif
  input_port #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_sw(sw), .i_rd(rd),
    .o_data(data), .o_valid(valid), .o_ovr(ovr)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d, input logic v, input logic o);
    exp_t e;
    e.d = d; e.v = v; e.o = o;
    q.push_back(e);
  endtask
  task automatic chk(input string tag);
    exp_t e, a;
    e = q.pop_front();
    a = {data, valid, ovr};
    n_assert++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s: observed data=%h valid=%b ovr=%b expected data=%h valid=%b ovr=%b",
             tag, a.d, a.v, a.o, e.d, e.v, e.o);
    end
  endtask
  initial begin
    // 1: switches nonzero through reset; commit lands on 7th edge after release
    sw = 8'hA5;
    #23;
    push(8'h00, 1'b0, 1'b0); chk("reset_state");
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      push(k < 7 ? 8'h00 : 8'hA5, k == 7, 1'b0);
      tick();
      chk($sformatf("startup_edge%0d", k));
    end
    // 2: read clears valid, data held
    rd = 1'b1;
    push(8'hA5, 1'b0, 1'b0);
    tick();
    rd = 1'b0;
    chk("read_clear");
    // 3: short glitch never commits
    sw = 8'h5A;
    tick(); tick();
    sw = 8'hA5;
    for (int k = 1; k <= 10; k++) begin
      push(8'hA5, 1'b0, 1'b0);
      tick();
      chk($sformatf("glitch_%0d", k));
    end
    // 4: read on the commit edge: new data wins, valid stays set
    sw = 8'hFF;
    for (int k = 1; k <= 7; k++) begin
      rd = (k == 7);
      push(k < 7 ? 8'hA5 : 8'hFF, k == 7, 1'b0);
      tick();
      rd = 1'b0;
      chk($sformatf("rd_on_commit_%0d", k));
    end
    // 5: commit while still valid -> overrun (only when feature built in)
    sw = 8'h00;
    for (int k = 1; k <= 7; k++) begin
      push(k < 7 ? 8'hFF : 8'h00, 1'b1, k == 7 ? OVR_EXP : 1'b0);
      tick();
      chk($sformatf("overrun_%0d", k));
    end
    rd = 1'b1;
    push(8'h00, 1'b0, 1'b0);
    tick();
    rd = 1'b0;
    chk("overrun_read");
    // 6: commit 3C, start a C3 window, reset at cnt=2 between edges
    sw = 8'h3C;
    for (int k = 1; k <= 7; k++) tick();
    push(8'h3C, 1'b1, 1'b0); chk("commit_3c");
    rd = 1'b1; tick(); rd = 1'b0;
    push(8'h3C, 1'b0, 1'b0); chk("read_3c");
    sw = 8'hC3;
    for (int k = 1; k <= 5; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    push(8'h00, 1'b0, 1'b0); chk("async_reset");
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      push(k < 7 ? 8'h00 : 8'hC3, k == 7, 1'b0);
      tick();
      chk($sformatf("after_reset_%0d", k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
